// File: rtl/irq_request_latch.sv
// rtl/irq_request_latch.sv - synchronised, edge-captured, maskable request latch feeding a 4-to-2 priority encoder (optional IRQ_OVERFLOW_EN)
module irq_request_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_id,
    output logic [3:0] d,
    output logic       irq,
    output logic [3:0] overflow,
    input  logic       ovf_clr
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][3:0]   sync_q, sync_d;
    logic [3:0]                    hist_q, hist_d;
    logic [3:0]                    pending_q, pending_d;
    logic [3:0]                    d_q, d_d;
    logic                          irq_q, irq_d;

    logic [3:0]                    rise;
    logic [3:0]                    clr_vec;
    logic [3:0]                    visible;
    logic                          ack_ok;

    // Synchroniser shift, history flop and rising-edge detect on the synchronised lines
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
        hist_d = sync_q[SYNC_STAGES-1];
        rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    // An ack only counts when it names a bit of the frozen snapshot; new edges beat the clear
    always_comb begin
        ack_ok    = (state_q == PRESENT) && ack && d_q[ack_id];
        clr_vec   = ack_ok ? (4'b0001 << ack_id) : 4'b0000;
        pending_d = (pending_q & ~clr_vec) | rise;
    end

    // Presentation FSM: load a snapshot from IDLE, hold it until a matching ack
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        irq_d   = irq_q;
        visible = pending_q & ~mask;
        case (state_q)
            IDLE: begin
                if (visible != 4'b0000) begin
                    d_d     = visible;
                    irq_d   = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack_ok) begin
                    d_d     = 4'b0000;
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                d_d     = 4'b0000;
                irq_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything immediately, including mid-presentation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            hist_q    <= 4'b0000;
            pending_q <= 4'b0000;
            d_q       <= 4'b0000;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            d_q       <= d_d;
            irq_q     <= irq_d;
        end
    end

    assign d   = d_q;
    assign irq = irq_q;

`ifdef IRQ_OVERFLOW_EN
    logic [3:0] overflow_q, overflow_d;

    // Sticky overflow: edge on an already-pending line that is not being cleared this cycle
    always_comb begin
        overflow_d = (overflow_q & ~{4{ovf_clr}}) | (rise & pending_q & ~clr_vec);
    end

    // Overflow register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 4'b0000;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_ovf_clr;

    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 4'b0000;
`endif

endmodule

// File: tb/tb_irq_request_latch.sv
// tb/tb_irq_request_latch.sv - scoreboard bench for irq_request_latch with a behavioural reference model
module tb_irq_request_latch;

    localparam int S = 2;
`ifdef IRQ_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_id;
    logic [3:0] d;
    logic       irq;
    logic [3:0] overflow;
    logic       ovf_clr;

    irq_request_latch #(.SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .mask     (mask),
        .ack      (ack),
        .ack_id   (ack_id),
        .d        (d),
        .irq      (irq),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic       irq;
        logic [3:0] ovf;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_hist[$];
    logic [3:0] m_pend;
    logic [3:0] m_d;
    logic       m_pres;
    logic [3:0] m_ovf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] top_idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    // Reference: samples of req_in per edge; a line event fires S edges after a 0->1 sample step
    task automatic model_step();
        logic [3:0] ev, clr, old_p;
        exp_t e;
        if (rst) begin
            m_pend = 4'b0; m_d = 4'b0; m_pres = 1'b0; m_ovf = 4'b0;
            m_hist.delete();
            for (int i = 0; i < S + 1; i++) m_hist.push_back(4'b0);
        end else begin
            ev  = m_hist[1] & ~m_hist[0];
            clr = (m_pres && ack && m_d[ack_id]) ? (4'b0001 << ack_id) : 4'b0000;
            old_p = m_pend;
            m_ovf  = (ovf_clr ? 4'b0 : m_ovf) | (ev & old_p & ~clr);
            m_pend = (old_p & ~clr) | ev;
            if (m_pres) begin
                if (clr != 4'b0) begin
                    m_pres = 1'b0;
                    m_d    = 4'b0;
                end
            end else if ((old_p & ~mask) != 4'b0) begin
                m_d    = old_p & ~mask;
                m_pres = 1'b1;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(req_in);
        end
        e.d   = m_d;
        e.irq = m_pres;
        e.ovf = OVF_EN ? m_ovf : 4'b0;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input logic [3:0] r, input logic [3:0] m, input logic a,
                         input logic [1:0] id, input logic oc);
        @(negedge clk);
        req_in = r; mask = m; ack = a; ack_id = id; ovf_clr = oc;
        @(posedge clk);
        model_step();
    endtask

    task automatic wait_present(input logic [3:0] r, input logic [3:0] m);
        int n;
        n = 0;
        while (!m_pres && n < 20) begin
            cycle(r, m, 1'b0, 2'd0, 1'b0);
            n++;
        end
        #1;
        chk("wait_present_bound", {31'b0, m_pres}, 32'd1);
    endtask

    // Monitor: compare each registered output set against the scoreboard after every edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_d", d, e.d);
            chk("mon_irq", irq, e.irq);
            chk("mon_overflow", overflow, e.ovf);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [3:0] r_cur, m_cur;
        logic       a;
        logic [1:0] id;

        rst = 1'b1; req_in = 4'b0; mask = 4'b0; ack = 1'b0; ack_id = 2'd0; ovf_clr = 1'b0;
        m_pend = 4'b0; m_d = 4'b0; m_pres = 1'b0; m_ovf = 4'b0;
        for (int i = 0; i < S + 1; i++) m_hist.push_back(4'b0);

        // Reset
        repeat (3) cycle(4'b0, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("reset_d", d, 4'b0000);
        chk("reset_irq", irq, 1'b0);
        chk("reset_overflow", overflow, 4'b0000);
        rst = 1'b0;
        repeat (10) cycle(4'b0, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("idle_irq", irq, 1'b0);

        // Single request: irq after edge k+3
        cycle(4'b0100, 4'b0, 1'b0, 2'd0, 1'b0);
        cycle(4'b0100, 4'b0, 1'b0, 2'd0, 1'b0);
        cycle(4'b0100, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("single_not_early", irq, 1'b0);
        cycle(4'b0100, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("single_irq", irq, 1'b1);
        chk("single_d", d, 4'b0100);
        cycle(4'b0000, 4'b0, 1'b1, 2'd2, 1'b0);
        #1;
        chk("single_ack_irq", irq, 1'b0);
        chk("single_ack_d", d, 4'b0000);
        repeat (5) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("single_quiet", irq, 1'b0);

        // Two lines, one-cycle gap between services
        wait_present(4'b1001, 4'b0);
        chk("multi_d", d, 4'b1001);
        cycle(4'b1001, 4'b0, 1'b1, 2'd3, 1'b0);
        #1;
        chk("multi_gap_irq", irq, 1'b0);
        cycle(4'b1001, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("multi_second_d", d, 4'b0001);
        chk("multi_second_irq", irq, 1'b1);
        cycle(4'b0000, 4'b0, 1'b1, 2'd0, 1'b0);
        repeat (4) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("multi_done_irq", irq, 1'b0);

        // Bad ack, mask change during presentation
        wait_present(4'b0010, 4'b0);
        chk("bad_d", d, 4'b0010);
        cycle(4'b0010, 4'b0, 1'b1, 2'd0, 1'b0);
        #1;
        chk("bad_ack_ignored", d, 4'b0010);
        repeat (3) cycle(4'b0010, 4'b0010, 1'b0, 2'd0, 1'b0);
        #1;
        chk("mask_stable_d", d, 4'b0010);
        cycle(4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);
        #1;
        chk("mask_ack_irq", irq, 1'b0);
        repeat (4) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);

        // Overflow: two edges on line 1 without an ack
        cycle(4'b0010, 4'b0, 1'b0, 2'd0, 1'b0);
        cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        cycle(4'b0010, 4'b0, 1'b0, 2'd0, 1'b0);
        repeat (4) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("ovf_set", overflow, OVF_EN ? 4'b0010 : 4'b0000);
        cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b1);
        #1;
        chk("ovf_clr", overflow, 4'b0000);
        cycle(4'b0000, 4'b0, 1'b1, 2'd1, 1'b0);
        repeat (3) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);

        // Asynchronous reset during presentation
        wait_present(4'b0100, 4'b0);
        chk("arst_pre_d", d, 4'b0100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_d", d, 4'b0000);
        chk("arst_irq", irq, 1'b0);
        repeat (2) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        repeat (8) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk("arst_quiet", irq, 1'b0);

        // Randomised traffic against the model
        r_cur = 4'b0;
        m_cur = 4'b0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) r_cur[i] = ~r_cur[i];
            if ($urandom_range(7) == 0) m_cur = 4'($urandom);
            a  = ($urandom_range(2) == 0);
            id = ($urandom_range(3) == 0) ? 2'($urandom) : top_idx(m_d);
            cycle(r_cur, m_cur, a, id, $urandom_range(15) == 0);
        end

        repeat (3) cycle(4'b0000, 4'b0, 1'b0, 2'd0, 1'b0);
        #2;
        chk("queue_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_request_latch.md
# irq_request_latch

Request-capture stage that drives the 4-bit request vector `d` of the 4-to-2 priority encoder. It synchronises four asynchronous request lines, detects rising edges, and holds them as pending bits with a per-line mask. It presents a stable snapshot to the encoder and clears the serviced bit when the consumer acknowledges it with the encoded index.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser flops per request line; legal range 2..3.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req_in`  input  4  raw asynchronous request lines; a rising edge raises a request.
- `mask`  input  4  1 = line disabled from presentation; its pending bit is still captured.
- `ack`  input  1  one-cycle acknowledge from the consumer of the encoder output.
- `ack_id`  input  2  index of the serviced line; equals the encoder output `a`.
- `d`  output  4  registered snapshot of `pending & ~mask`; feeds the encoder's `d`.
- `irq`  output  1  registered; high while a snapshot is presented.
- `overflow`  output  4  sticky per-line flag: a new edge arrived while that line was already pending.
- `ovf_clr`  input  1  synchronous clear of all `overflow` bits.

## Operation
- Synchroniser: `SYNC_STAGES` flops per line, then one history flop. An edge is `sync & ~hist`.
- Pending: an edge on line i sets `pending[i]`. A clear removes it only through an accepted ack.
- Set and clear of the same bit in the same cycle: set wins, so the bit stays 1 and `overflow` is not flagged.
- FSM states:
  - IDLE: `irq`=0, `d`=0. If `(pending & ~mask) != 0`, load the snapshot into `d`, set `irq`=1, and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: `d` and `irq` are frozen. Mask changes and new pending bits do not alter the snapshot. If `ack`=1 and `d[ack_id]`=1, clear `pending[ack_id]`, zero `d` and `irq`, and go to IDLE. If `ack`=1 and `d[ack_id]`=0, ignore the ack and stay in PRESENT.
- `ack` in IDLE is ignored.
- Masked pending bits stay pending. They are presented once unmasked.

## Timing
- Reset values: `d`=0, `irq`=0, `overflow`=0, `pending`=0, all synchroniser and history flops 0, FSM=IDLE.
- A line already high at reset release is seen as a rising edge.
- Capture latency: `req_in` rises before edge k. `pending` is set after edge k+`SYNC_STAGES`-1+1, i.e. after edge k+2 for the default. `irq` and `d` are valid after the following edge (k+3 for the default).
- Ack is sampled at edge m. `irq`/`d` read 0 after edge m.
- IDLE lasts at least one cycle after an ack. If further bits are pending, the new snapshot appears after edge m+1, so `irq` is low for exactly 1 cycle between services.
- Reset asserted mid-PRESENT: all outputs go to their reset values immediately, without waiting for a clock edge.
- `ovf_clr` and a new overflow event in the same cycle: set wins.

## Configuration
- `IRQ_OVERFLOW_EN` defined: the `overflow` register and `ovf_clr` logic are compiled in as described above.
- `IRQ_OVERFLOW_EN` undefined:
  - `overflow` is tied to 4'b0000.
  - `ovf_clr` is ignored.
  - No overflow flops are instantiated.
  - Pending behaviour is unchanged.

## Test plan
- Reset: assert `rst` with `req_in`=0000. Required: `d`=0000, `irq`=0, `overflow`=0000. Hold `req_in`=0000 for 10 cycles; `irq` must stay 0.
- Single request: pulse `req_in[2]` 0→1. Required: `irq`=1 and `d`=0100 exactly 3 edges later. Then `ack`=1 with `ack_id`=2. Required: `irq`=0 and `d`=0000 on the next cycle, and nothing further is presented.
- Multiple requests with one-cycle gap: raise lines 0 and 3 together. Required: `d`=1001. Ack with `ack_id`=3. Required: `irq` low for 1 cycle, then `d`=0001. Ack with `ack_id`=0. Required: `irq` stays 0.
- Bad ack, mask and snapshot stability: `d`=0010 presented; ack with `ack_id`=0. Required: ignored, `d` stays 0010. Set `mask`=0010 during PRESENT. Required: `d` is unchanged until a valid ack with `ack_id`=1.
- Overflow (macro defined): two rising edges on line 1 with no ack in between. Required: `overflow`=0010. Pulse `ovf_clr`. Required: `overflow`=0000. With the macro undefined, the same stimulus gives `overflow`=0000.
- Asynchronous reset mid-PRESENT: with `d`=0100 and `irq`=1, assert `rst` between clock edges. Required: `d`=0000 and `irq`=0 before the next edge. After release, nothing is presented while `req_in`=0000.
